// File: rtl/pc_lut_pkg.sv
// rtl/pc_lut_pkg.sv - shared types and default widths for the PC target table
package pc_lut_pkg;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;

  typedef enum logic {CLEAR, READY} state_t;

  typedef struct packed {
    logic            valid;
    logic            rel;
    logic [PC_W-1:0] data;
  } bt_entry_t;

endpackage

// File: rtl/pc_target_resolve.sv
// rtl/pc_target_resolve.sv - turns one table entry plus the branch PC into a next-PC target
module pc_target_resolve
  import pc_lut_pkg::*;
#(
  parameter int D      = PC_W,
  parameter bit REL_EN = 1'b1
) (
  input  logic         valid,
  input  logic         rel,
  input  logic [D-1:0] data,
  input  logic [D-1:0] pc_in,
  output logic [D-1:0] target,
  output logic         miss
);

  // Sums are D bits wide, so the carry-out drops and results wrap modulo 2^D.
  always_comb begin
    target = pc_in + D'(1);
    miss   = 1'b1;
    if (valid) begin
      miss = 1'b0;
      if (REL_EN && rel) target = pc_in + data;
      else               target = data;
    end
  end

endmodule

// File: rtl/pc_target_table.sv
// rtl/pc_target_table.sv - programmable branch-target table with sequential clear after reset
module pc_target_table
  import pc_lut_pkg::*;
#(
  parameter int D      = PC_W,
  parameter int AW     = IDX_W,
  parameter bit REL_EN = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_rel,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [D-1:0]  pc_in,
  output logic          rd_valid,
  output logic [D-1:0]  target,
  output logic          miss,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;

  state_t          state;
  logic [AW-1:0]   clr_ptr;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rel_q;
  logic [D-1:0]    data_q [DEPTH];

  logic            bypass;
  logic            lk_valid;
  logic            lk_rel;
  logic [D-1:0]    lk_data;
  logic [D-1:0]    res_target;
  logic            res_miss;

  // Write-first: a same-cycle write to the looked-up index wins over the stored entry.
  assign bypass   = wr_en && (wr_addr == rd_addr);
  assign lk_valid = bypass ? 1'b1    : valid_q[rd_addr];
  assign lk_rel   = bypass ? wr_rel  : rel_q[rd_addr];
  assign lk_data  = bypass ? wr_data : data_q[rd_addr];

  pc_target_resolve #(.D(D), .REL_EN(REL_EN)) u_resolve (
    .valid  (lk_valid),
    .rel    (lk_rel),
    .data   (lk_data),
    .pc_in  (pc_in),
    .target (res_target),
    .miss   (res_miss)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      rd_valid <= 1'b0;
      target   <= '0;
      miss     <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          valid_q[clr_ptr] <= 1'b0;
          clr_ptr          <= clr_ptr + 1'b1;
          rd_valid         <= 1'b0;
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (wr_en) begin
            valid_q[wr_addr] <= 1'b1;
            rel_q[wr_addr]   <= wr_rel;
          end
          rd_valid <= rd_req;
          if (rd_req) begin
            target <= res_target;
            miss   <= res_miss;
          end
        end
      endcase
    end
  end

  // Payload needs no reset; the valid bits gate it.
  always_ff @(posedge Clk) begin
    if (!Reset && state == READY && wr_en) data_q[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_pc_target_table.sv
// tb/tb_pc_target_table.sv - scoreboard bench for pc_target_table, REL_EN=1 and REL_EN=0 side by side
module tb_pc_target_table;

  logic       Clk = 1'b0;
  logic       Reset, wr_en, wr_rel, rd_req;
  logic [3:0] wr_addr, rd_addr;
  logic [9:0] wr_data, pc_in;
  logic       rv1, m1, b1, rv0, m0, b0;
  logic [9:0] t1, t0;

  always #5 Clk = ~Clk;

  pc_target_table #(.D(10), .AW(4), .REL_EN(1'b1)) u_rel (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rel(wr_rel), .rd_req(rd_req), .rd_addr(rd_addr), .pc_in(pc_in),
    .rd_valid(rv1), .target(t1), .miss(m1), .busy(b1));

  pc_target_table #(.D(10), .AW(4), .REL_EN(1'b0)) u_abs (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rel(wr_rel), .rd_req(rd_req), .rd_addr(rd_addr), .pc_in(pc_in),
    .rd_valid(rv0), .target(t0), .miss(m0), .busy(b0));

  typedef struct {
    int t1; int t0; bit m;
    bit dchk; int dt1; int dt0; bit dm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_err = 0;

  // Reference model state: plain arrays plus a countdown for the clear window.
  bit   mv[16];
  bit   mr[16];
  int   md[16];
  int   cnt = 16;
  bit   e_busy, e_rv, started = 0;
  int   h1, h0;
  bit   hm;

  bit   dir_chk, dir_m;
  int   dir_t1, dir_t0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    exp_t it;
    int a, p;
    if (Reset) begin
      for (int i = 0; i < 16; i++) mv[i] = 0;
      cnt = 16; e_busy = 1; e_rv = 0; h1 = 0; h0 = 0; hm = 0; started = 1;
    end else if (cnt > 0) begin
      cnt--;
      e_busy = (cnt != 0);
      e_rv = 0;
    end else begin
      if (wr_en) begin
        mv[int'(wr_addr)] = 1;
        mr[int'(wr_addr)] = wr_rel;
        md[int'(wr_addr)] = int'(wr_data);
      end
      e_rv = rd_req;
      if (rd_req) begin
        a = int'(rd_addr);
        p = int'(pc_in);
        if (!mv[a]) begin
          it.m = 1; it.t1 = (p + 1) % 1024; it.t0 = it.t1;
        end else begin
          it.m = 0; it.t0 = md[a];
          it.t1 = mr[a] ? (p + md[a]) % 1024 : md[a];
        end
        it.dchk = dir_chk; it.dt1 = dir_t1; it.dt0 = dir_t0; it.dm = dir_m;
        exp_q.push_back(it);
        h1 = it.t1; h0 = it.t0; hm = it.m;
      end
    end
  end

  always @(negedge Clk) begin
    exp_t it;
    if (started) begin
      chk("busy_rel", int'(b1), int'(e_busy));
      chk("busy_abs", int'(b0), int'(e_busy));
      chk("rd_valid_rel", int'(rv1), int'(e_rv));
      chk("rd_valid_abs", int'(rv0), int'(e_rv));
      if (e_rv) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 0, 1);
        end else begin
          it = exp_q.pop_front();
          chk("target_rel", int'(t1), it.t1);
          chk("target_abs", int'(t0), it.t0);
          chk("miss_rel", int'(m1), int'(it.m));
          chk("miss_abs", int'(m0), int'(it.m));
          if (it.dchk) begin
            chk("plan_target_rel", int'(t1), it.dt1);
            chk("plan_target_abs", int'(t0), it.dt0);
            chk("plan_miss", int'(m1), int'(it.dm));
          end
        end
      end else begin
        chk("hold_target_rel", int'(t1), h1);
        chk("hold_target_abs", int'(t0), h0);
        chk("hold_miss", int'(m1), int'(hm));
      end
    end
  end

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic drive(bit we, int wa, int wd, bit wrl, bit re, int ra, int pc,
                       bit dc, int d1, int d0, bit dm);
    wr_en = we; wr_addr = 4'(wa); wr_data = 10'(wd); wr_rel = wrl;
    rd_req = re; rd_addr = 4'(ra); pc_in = 10'(pc);
    dir_chk = dc; dir_t1 = d1; dir_t0 = d0; dir_m = dm;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1;
    idle(2);
    Reset = 0;
    drive(0, 0, 0, 0, 1, 3, 7, 0, 0, 0, 0);
    idle(16);
    drive(0, 0, 0, 0, 1, 3, 7, 1, 8, 8, 1);
    drive(1, 2, 81, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 2, 500, 1, 81, 81, 0);
    drive(1, 5, 'h3FB, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 4, 1, 1023, 1019, 0);
    drive(1, 6, 20, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 6, 1020, 1, 16, 20, 0);
    drive(1, 9, 120, 0, 1, 9, 0, 1, 120, 120, 0);
    drive(1, 9, 120, 0, 1, 8, 0, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 2, 100, 1, 81, 81, 0);
    drive(0, 0, 0, 0, 1, 5, 100, 1, 95, 1019, 0);
    drive(0, 0, 0, 0, 1, 9, 100, 1, 120, 120, 0);
    drive(0, 0, 0, 0, 1, 0, 100, 1, 101, 101, 1);
    idle(2);
    Reset = 1;
    idle(1);
    Reset = 0;
    idle(17);
    drive(0, 0, 0, 0, 1, 2, 1023, 1, 0, 0, 1);
    idle(1);

    for (int i = 0; i < 600; i++) begin
      int wa, ra, pc;
      Reset = ($urandom_range(0, 199) == 0);
      wa = $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      pc = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023);
      drive($urandom_range(0, 1) == 1, wa, $urandom_range(0, 1023), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, ra, pc, 0, 0, 0, 0);
    end
    Reset = 0;
    idle(3);
    chk("leftover_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
- Run-time programmable branch-target table; replaces the fixed-constant PC lookup used by the fetch stage.
- A branch supplies a small index and the current PC. The block returns the next-PC target one cycle later.
- Each entry is absolute or PC-relative (offset added modulo 2^D). Unprogrammed entries fall through to PC+1 and flag a miss.
- Entries are written by the loader/controller through a single write port. Every entry is invalidated by a sequential clear after Reset.

Parameters:
- D, 10, PC/target width in bits.
- AW, 4, index width; table depth = 2^AW entries.
- REL_EN, 1, 1 = relative entries honoured; 0 = the rel bit is ignored and every entry is treated as absolute.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; accepted only when busy=0.
- wr_addr  input  AW  entry index to write.
- wr_data  input  D  absolute target, or two's-complement offset when wr_rel=1.
- wr_rel  input  1  entry mode for this write.
- rd_req  input  1  lookup request.
- rd_addr  input  AW  lookup index.
- pc_in  input  D  PC of the requesting branch; sampled together with rd_req.
- rd_valid  output  1  target and miss are valid this cycle.
- target  output  D  resolved next PC.
- miss  output  1  looked-up entry was not valid; target = pc_in+1.
- busy  output  1  clear sequence in progress.

Behaviour:
- FSM states: CLEAR, READY.
- Reset=1 at an edge:
  - state<=CLEAR, clr_ptr<=0.
  - rd_valid<=0, target<=0, miss<=0, busy<=1.
  - Holds for as long as Reset stays high. Reset asserted mid-clear or mid-lookup restarts the clear from index 0.
- CLEAR:
  - Each cycle, valid[clr_ptr]<=0 and clr_ptr increments.
  - When clr_ptr = 2^AW-1 is cleared, go to READY and drop busy in that same edge.
  - Total: busy high for exactly 2^AW cycles after Reset deasserts.
  - wr_en and rd_req are ignored. A rd_req in CLEAR produces rd_valid=0 next cycle.
- READY, write: wr_en=1 at an edge sets entry[wr_addr] <= {valid=1, rel=wr_rel, data=wr_data}. Rewriting an existing entry overwrites it.
- READY, lookup:
  - rd_req=1 at edge N gives rd_valid=1 during cycle N+1 (1-cycle registered latency). rd_req=0 gives rd_valid=0 next cycle.
  - Back-to-back requests are supported, one per cycle.
  - target and miss hold their last value while rd_valid=0.
- Resolution:
  - valid=0 -> target = pc_in+1 mod 2^D, miss=1.
  - valid=1, rel=0 (or REL_EN=0) -> target = data, miss=0.
  - valid=1, rel=1, REL_EN=1 -> target = (pc_in + data) mod 2^D. Data is a D-bit two's-complement value; the carry-out is discarded. miss=0.
- Simultaneous write and read to the same index: write-first bypass. The lookup resolves with the incoming wr_data/wr_rel and valid=1. A different index is unaffected.
- Wrap-around: pc_in=2^D-1 with a miss gives target 0. A relative result wraps the same way.
- No read/write error conditions exist; every index is in range by width.

Decomposition:
- Shared package pc_lut_pkg:
  - Localparams PC_W=10 and IDX_W=4.
  - Typedef enum logic {CLEAR, READY} state_t.
  - Packed struct bt_entry_t {logic valid; logic rel; logic [PC_W-1:0] data}.
- The module takes D/AW as parameters; the package values are the defaults the top level passes in.
- One natural sub-module: pc_target_resolve.
  - Purely combinational mux plus modulo-2^D adder.
  - Inputs: entry, pc_in, REL_EN.
  - Outputs: target, miss.
  - Reused by the fetch-stage fall-through.

Test Plan:
- Reset for 2 cycles, then release -> busy=1 for exactly 16 cycles, then 0. A rd_req(addr 3, pc 7) during CLEAR gives rd_valid=0. After busy=0, rd_req(addr 3, pc 7) gives rd_valid=1, miss=1, target=8.
- Write addr 2, absolute, data 81; next cycle rd_req(addr 2, pc 500) -> one cycle later rd_valid=1, miss=0, target=81.
- Write addr 5, rel, data 0x3FB (-5); rd_req(addr 5, pc 4) -> target=1023 (wraps). Write addr 6, rel, data 20; rd_req(addr 6, pc 1020) -> target=16. Repeat with REL_EN=0: addr 6 gives target=20.
- Same-cycle wr_en(addr 9, data 120, abs) and rd_req(addr 9, pc 0) -> next cycle target=120, miss=0 (bypass). A same-cycle read of addr 8 instead gives miss=1, target=1.
- Four back-to-back rd_req on addrs 2,5,9,0 -> rd_valid high for four consecutive cycles with the per-entry targets in order.
- Reset pulsed for 1 cycle while in READY after programming -> busy high for 16 cycles. Afterwards, rd_req(addr 2, pc 1023) gives miss=1, target=0.
